// File: rtl/manchester_tx_sched.sv
// Two-requester round-robin scheduler feeding one Manchester half-symbol line.
// Latency: ackN is combinational in the grant cycle; the first preamble half-symbol appears the next cycle.
// Backpressure: requesters hold req/data until acked; no grants while a frame or inter-frame gap is active.
//
// Ports:
//   clkin, rst         clock (posedge) and synchronous active-high reset
//   req0/data0/ack0    requester 0: pending flag, byte, one-cycle capture pulse
//   req1/data1/ack1    requester 1: pending flag, byte, one-cycle capture pulse
//   line_out           Manchester half-symbols (bit 1 -> 1,0 ; bit 0 -> 0,1)
//   tx_en              high while a frame is on the line
//   busy               high whenever not idle
//   grant_id           channel of the current or last frame
//   frame_done         one-cycle pulse in the first cycle after the parity bit
module manchester_tx_sched #(
   parameter int HALF_DIV = 1,
   parameter int PRE_LEN  = 4,
   parameter int GAP_BITS = 2
) (
   input  logic       clkin,
   input  logic       rst,
   input  logic       req0,
   input  logic [7:0] data0,
   output logic       ack0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       ack1,
   output logic       line_out,
   output logic       tx_en,
   output logic       busy,
   output logic       grant_id,
   output logic       frame_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_CHID, S_DATA, S_PAR, S_GAP
   } state_t;

   localparam int            HW       = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [HW-1:0] HLAST    = HW'(HALF_DIV - 1);
   localparam logic [3:0]    PRE_LAST = 4'(PRE_LEN - 1);
   localparam logic [3:0]    GAP_LAST = 4'(GAP_BITS - 1);

   state_t        state_q, state_d;
   logic [HW-1:0] hcnt_q,  hcnt_d;
   logic          phase_q, phase_d;   // 0: first half-symbol, 1: second
   logic [3:0]    bcnt_q,  bcnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q,   par_d;
   logic          gid_q,   gid_d;
   logic          last_q,  last_d;
   logic          fdone_q, fdone_d;

   logic       gnt_vld, gnt_ch, half_end, bit_end, cur_bit;
   logic [7:0] gnt_dat;
   logic [3:0] bit_last;

   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q <= S_IDLE;
         hcnt_q  <= '0;
         phase_q <= 1'b0;
         bcnt_q  <= 4'd0;
         shreg_q <= 8'd0;
         par_q   <= 1'b0;
         gid_q   <= 1'b0;
         last_q  <= 1'b1;   // makes ch0 win the first tie
         fdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         phase_q <= phase_d;
         bcnt_q  <= bcnt_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         gid_q   <= gid_d;
         last_q  <= last_d;
         fdone_q <= fdone_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      hcnt_d   = hcnt_q;
      phase_d  = phase_q;
      bcnt_d   = bcnt_q;
      shreg_d  = shreg_q;
      par_d    = par_q;
      gid_d    = gid_q;
      last_d   = last_q;
      fdone_d  = 1'b0;
      ack0     = 1'b0;
      ack1     = 1'b0;
      cur_bit  = 1'b0;
      bit_last = 4'd0;

      // Round robin: a tie goes to the channel that did not win last time.
      gnt_vld  = req0 | req1;
      gnt_ch   = (req0 & req1) ? ~last_q : req1;
      gnt_dat  = gnt_ch ? data1 : data0;

      half_end = (hcnt_q == HLAST);
      bit_end  = half_end & phase_q;

      case (state_q)
         S_PRE:   begin cur_bit = 1'b1;       bit_last = PRE_LAST; end
         S_CHID:  begin cur_bit = gid_q;      bit_last = 4'd0;     end
         S_DATA:  begin cur_bit = shreg_q[7]; bit_last = 4'd7;     end
         S_PAR:   begin cur_bit = par_q;      bit_last = 4'd0;     end
         S_GAP:   begin cur_bit = 1'b0;       bit_last = GAP_LAST; end
         default: begin cur_bit = 1'b0;       bit_last = 4'd0;     end
      endcase

      if (state_q == S_IDLE) begin
         hcnt_d  = '0;
         phase_d = 1'b0;
         bcnt_d  = 4'd0;
         // Acks are gated by rst so a reset cycle never captures a byte.
         if (gnt_vld && !rst) begin
            ack0    = ~gnt_ch;
            ack1    = gnt_ch;
            shreg_d = gnt_dat;
            par_d   = gnt_ch ^ (^gnt_dat);   // even parity over chid + data
            gid_d   = gnt_ch;
            last_d  = gnt_ch;
            state_d = S_PRE;
         end
      end else begin
         hcnt_d = half_end ? '0 : hcnt_q + 1'b1;
         if (half_end) phase_d = ~phase_q;
         if (bit_end) begin
            if (state_q == S_DATA) shreg_d = {shreg_q[6:0], 1'b0};
            if (bcnt_q == bit_last) begin
               bcnt_d = 4'd0;
               case (state_q)
                  S_PRE:  state_d = S_CHID;
                  S_CHID: state_d = S_DATA;
                  S_DATA: state_d = S_PAR;
                  S_PAR: begin
                     fdone_d = 1'b1;
                     state_d = (GAP_BITS == 0) ? S_IDLE : S_GAP;
                  end
                  default: state_d = S_IDLE;
               endcase
            end else begin
               bcnt_d = bcnt_q + 4'd1;
            end
         end
      end
   end

   assign tx_en      = (state_q == S_PRE) || (state_q == S_CHID) ||
                       (state_q == S_DATA) || (state_q == S_PAR);
   assign busy       = (state_q != S_IDLE);
   assign line_out   = tx_en & (cur_bit ^ phase_q);
   assign grant_id   = gid_q;
   assign frame_done = fdone_q;

endmodule
